// File: rtl/bit_debounce.sv
// Single-bit input conditioner: synchronizer chain followed by a run-length
// debounce counter, producing a clean registered level plus rise/fall strobes.
module bit_debounce #(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall,
    output logic busy
);

    localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_r;
    logic [CNT_W-1:0]       cnt_r;
    logic                   q_r;
    logic                   rise_r;
    logic                   fall_r;
    logic                   d_s;
    logic                   mismatch_s;

    // Pure shift chain: nothing may sit between stages so metastability can settle.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], d};
        end
    end

    assign d_s        = sync_r[SYNC_STAGES-1];
    assign mismatch_s = d_s ^ q_r;

    // Qualify a candidate level; commit only after an unbroken mismatch run.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= CNT_ZERO;
            q_r    <= 1'b0;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (!mismatch_s) begin
            cnt_r  <= CNT_ZERO;
            q_r    <= q_r;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_r  <= CNT_ZERO;
            q_r    <= d_s;
            rise_r <= d_s;
            fall_r <= ~d_s;
        end else begin
            cnt_r  <= cnt_r + CNT_ONE;
            q_r    <= q_r;
            rise_r <= 1'b0;
            fall_r <= 1'b0;
        end
    end

    assign q    = q_r;
    assign rise = rise_r;
    assign fall = fall_r;
    // Both operands are flop outputs, so busy cannot glitch on d activity.
    assign busy = mismatch_s;

endmodule

// File: tb/tb_bit_debounce.sv
// Self-checking bench for bit_debounce: directed vector table, hand-written
// corner sequences, and randomized bouncing input against a reference model.
module tb_bit_debounce;

    localparam int SS = 2;
    localparam int SC = 4;

    logic clk;
    logic rst, d, q, rise, fall, busy;
    logic rst2, d2, q2, rise2, fall2, busy2;

    int n_checks;
    int n_fail;

    bit_debounce dut (
        .clk(clk), .rst(rst), .d(d), .q(q), .rise(rise), .fall(fall), .busy(busy)
    );

    bit_debounce #(.SYNC_STAGES(3), .STABLE_CYCLES(1)) dut2 (
        .clk(clk), .rst(rst2), .d(d2), .q(q2), .rise(rise2), .fall(fall2), .busy(busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: q commits at edge n when the synchronized samples seen
    // at the last SC edges (all since the last commit/reset) differ from q.
    logic d_hist [0:8191];
    int   n_edge = 1;
    int   rst_edge = 0;
    int   last_commit = 0;
    logic q_m, rise_m, fall_m, busy_m;

    function automatic logic ds_at(input int e);
        int s;
        s = e - SS;
        return (s > rst_edge) ? d_hist[s] : 1'b0;
    endfunction

    always @(posedge clk) begin : model
        automatic bit commit;
        automatic logic q_new;
        d_hist[n_edge] <= d;
        n_edge <= n_edge + 1;
        if (rst) begin
            rst_edge    <= n_edge;
            last_commit <= n_edge;
            q_m    <= 1'b0;
            rise_m <= 1'b0;
            fall_m <= 1'b0;
            busy_m <= 1'b0;
        end else begin
            commit = 1'b1;
            for (int j = 0; j < SC; j++) begin
                if ((n_edge - j) <= last_commit || ds_at(n_edge - j) == q_m) commit = 1'b0;
            end
            q_new = commit ? ~q_m : q_m;
            if (commit) last_commit <= n_edge;
            rise_m <= commit & ~q_m;
            fall_m <= commit & q_m;
            q_m    <= q_new;
            busy_m <= (ds_at(n_edge + 1) != q_new);
        end
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic rst;
        logic d;
        logic q;
        logic rise;
        logic fall;
        logic busy;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic dv, input logic eq,
                                input logic er, input logic ef, input logic eb);
        vec_t v;
        v.rst = r; v.d = dv; v.q = eq; v.rise = er; v.fall = ef; v.busy = eb;
        vecs.push_back(v);
    endfunction

    initial begin
        int run_left;
        logic dv;
        int rises2, falls2;
        n_checks = 0;
        n_fail   = 0;
        rst = 1'b1; d = 1'b0; rst2 = 1'b1; d2 = 1'b0;

        // reset with d toggling, then release with d=0
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // clean rise: E0 .. E0+6
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        // clean fall
        add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 4; k++) add(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        // bounce: 1,1,1,0 then 1 held
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 5; k <= 8; k++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        add(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        foreach (vecs[i]) begin
            rst = vecs[i].rst;
            d   = vecs[i].d;
            step();
            check($sformatf("vec%0d.q", i),    q,    vecs[i].q);
            check($sformatf("vec%0d.rise", i), rise, vecs[i].rise);
            check($sformatf("vec%0d.fall", i), fall, vecs[i].fall);
            check($sformatf("vec%0d.busy", i), busy, vecs[i].busy);
        end

        // reset in the middle of a rise qualification
        rst = 1'b1; d = 1'b0;
        step(); step();
        rst = 1'b0; d = 1'b1;
        for (int k = 0; k < 4; k++) step();
        check("midq.cnt_before", (dut.cnt_r == 2'd2), 1'b1);
        check("midq.busy_before", busy, 1'b1);
        rst = 1'b1;
        step();
        check("midq.q_rst", q, 1'b0);
        check("midq.rise_rst", rise, 1'b0);
        check("midq.busy_rst", busy, 1'b0);
        check("midq.cnt_rst", (dut.cnt_r == 2'd0), 1'b1);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("midq.rise_k%0d", k), rise, (k == 5));
            check($sformatf("midq.q_k%0d", k), q, (k >= 5));
        end

        // STABLE_CYCLES=1, SYNC_STAGES=3: single-cycle pulse
        rst2 = 1'b0;
        step();
        d2 = 1'b1;
        step();
        d2 = 1'b0;
        rises2 = 0; falls2 = 0;
        for (int k = 1; k <= 6; k++) begin
            step();
            rises2 += int'(rise2);
            falls2 += int'(fall2);
            check($sformatf("sc1.q_k%0d", k), q2, (k == 3));
            check($sformatf("sc1.rise_k%0d", k), rise2, (k == 3));
            check($sformatf("sc1.fall_k%0d", k), fall2, (k == 4));
        end
        check("sc1.one_rise", (rises2 == 1), 1'b1);
        check("sc1.one_fall", (falls2 == 1), 1'b1);

        // randomized bouncing input against the model
        rst = 1'b1; d = 1'b0;
        step(); step();
        rst = 1'b0;
        dv = 1'b0;
        run_left = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run_left == 0) begin
                dv = ~dv;
                run_left = $urandom_range(1, 7);
            end
            run_left--;
            d   = dv;
            rst = ($urandom_range(0, 199) == 0);
            step();
            check("rand.q", q, q_m);
            check("rand.rise", rise, rise_m);
            check("rand.fall", fall, fall_m);
            check("rand.busy", busy, busy_m);
            check("rand.not_both", rise & fall, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
